// File: rtl/traffic_pkg.sv
// Shared state codes, lamp encodings and the state-to-lamp decode for the
// intersection controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        S_NS_GREEN  = 3'd0,
        S_NS_YELLOW = 3'd1,
        S_ALLRED_A  = 3'd2,
        S_EW_GREEN  = 3'd3,
        S_EW_YELLOW = 3'd4,
        S_ALLRED_B  = 3'd5,
        S_PED_WALK  = 3'd6,
        S_FLASH     = 3'd7
    } state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
    } lamps_t;

    function automatic lamps_t decode(state_t s, logic blink);
        lamps_t l;
        l = '{ns: LAMP_RED, ew: LAMP_RED, walk: 1'b0};
        case (s)
            S_NS_GREEN:  l.ns = LAMP_GRN;
            S_NS_YELLOW: l.ns = LAMP_YEL;
            S_EW_GREEN:  l.ew = LAMP_GRN;
            S_EW_YELLOW: l.ew = LAMP_YEL;
            S_PED_WALK:  l.walk = 1'b1;
            S_FLASH: begin
                l.ns = blink ? LAMP_YEL : LAMP_OFF;
                l.ew = blink ? LAMP_YEL : LAMP_OFF;
            end
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter advanced by the one-per-second tick; holds at zero
// until the controller reloads it.
module phase_timer #(
    parameter int              TW      = 8,
    parameter logic [TW-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic [TW-1:0] count,
    output logic          zero
);

    assign zero = (count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= RST_VAL;
        else if (load)
            count <= load_val;
        else if (tick && !zero)
            count <= count - 1'b1;
    end

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-way intersection controller with pedestrian phase and night flashing.
// All phase timing is in ticks; lamps are registered from the next state.
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int T_GREEN  = 10,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 2,
    parameter int T_WALK   = 8,
    parameter int TW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          ped_req,
    input  logic          night,
    output logic [2:0]    ns_light,
    output logic [2:0]    ew_light,
    output logic          walk,
    output logic [TW-1:0] secs_left,
    output logic [2:0]    phase
);

    state_t        state, nxt;
    logic          blink, nxt_blink;
    logic [1:0]    ped_sync, night_sync;
    logic          ped_prev, ped_pending;
    logic          ped_rise, night_s;
    logic          load, zero;
    logic [TW-1:0] load_val, timer;

    assign night_s  = night_sync[1];
    assign ped_rise = ped_sync[1] & ~ped_prev;

    function automatic logic [TW-1:0] dur_m1(state_t s);
        case (s)
            S_NS_GREEN, S_EW_GREEN:   return TW'(T_GREEN - 1);
            S_NS_YELLOW, S_EW_YELLOW: return TW'(T_YELLOW - 1);
            S_ALLRED_A, S_ALLRED_B:   return TW'(T_ALLRED - 1);
            S_PED_WALK:               return TW'(T_WALK - 1);
            default:                  return '0;
        endcase
    endfunction

    phase_timer #(.TW(TW), .RST_VAL(TW'(T_ALLRED - 1))) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .count    (timer),
        .zero     (zero)
    );

    // Night mode is only looked at on all-red exits, so lit phases always run
    // to completion.
    always_comb begin
        nxt       = state;
        nxt_blink = blink;
        if (tick) begin
            if (state == S_FLASH) begin
                if (night_s) nxt_blink = ~blink;
                else         nxt       = S_ALLRED_B;
            end else if (zero) begin
                case (state)
                    S_NS_GREEN:  nxt = S_NS_YELLOW;
                    S_NS_YELLOW: nxt = S_ALLRED_A;
                    S_ALLRED_A:  nxt = night_s ? S_FLASH : S_EW_GREEN;
                    S_EW_GREEN:  nxt = S_EW_YELLOW;
                    S_EW_YELLOW: nxt = S_ALLRED_B;
                    S_ALLRED_B:  nxt = night_s ? S_FLASH :
                                       ped_pending ? S_PED_WALK : S_NS_GREEN;
                    S_PED_WALK:  nxt = S_NS_GREEN;
                    default:     nxt = state;
                endcase
            end
        end
        load     = (nxt != state) && (nxt != S_FLASH);
        load_val = dur_m1(nxt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_ALLRED_B;
            blink       <= 1'b0;
            ped_sync    <= '0;
            night_sync  <= '0;
            ped_prev    <= 1'b0;
            ped_pending <= 1'b0;
            ns_light    <= LAMP_RED;
            ew_light    <= LAMP_RED;
            walk        <= 1'b0;
        end else begin
            state      <= nxt;
            blink      <= nxt_blink;
            ped_sync   <= {ped_sync[0], ped_req};
            night_sync <= {night_sync[0], night};
            ped_prev   <= ped_sync[1];
            // A press landing on the walk-entry cycle is consumed by that walk.
            if (nxt == S_PED_WALK && state != S_PED_WALK)
                ped_pending <= 1'b0;
            else if (ped_rise && state != S_PED_WALK)
                ped_pending <= 1'b1;
            {ns_light, ew_light, walk} <= decode(nxt, nxt_blink);
        end
    end

    assign secs_left = (state == S_FLASH) ? '0 : timer + TW'(1);
    assign phase     = state;

endmodule
